// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response
// and the valid/ready handshake toward decode.
interface fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    output o_valid,
    output o_instr,
    output o_pc,
    input  i_ready
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata,
    input  o_valid,
    input  o_instr,
    input  o_pc,
    output i_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request,
// small instruction queue toward decode, redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  fetch_unit_if.master bus
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   req_pc;
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic        req;
  logic        issue;
  logic        push;
  logic        pop;
  logic        valid;
  logic [31:0] redir_pc;

  // Request gating, queue push/pop qualifiers and head view.
  always_comb begin
    valid    = (count != '0);
    req      = (state == REQ) && (count < DEPTH) && !i_redirect;
    issue    = req && bus.i_imem_gnt;
    push     = (state == WAIT) && bus.i_imem_rvalid && !i_redirect;
    pop      = valid && bus.i_ready && !i_redirect;
    redir_pc = i_redirect_pc & 32'hFFFF_FFFC;

    bus.o_imem_req  = req;
    bus.o_imem_addr = fpc;
    bus.o_valid     = valid;
    bus.o_instr     = valid ? q_instr[head] : NOP;
    bus.o_pc        = valid ? q_pc[head] : 32'h0;
  end

  // Fetch FSM, fetch PC and queue bookkeeping; redirect wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= REQ;
      fpc    <= RESET_PC;
      req_pc <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      fpc   <= redir_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      unique case (state)
        REQ:     state <= REQ;
        WAIT:    state <= bus.i_imem_rvalid ? REQ : DROP;
        DROP:    state <= bus.i_imem_rvalid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
      unique case (state)
        REQ: begin
          if (issue) begin
            req_pc <= fpc;
            fpc    <= fpc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: if (bus.i_imem_rvalid) state <= REQ;
        DROP: if (bus.i_imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  // Queue storage; the slot is reserved at issue so push never overflows.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_instr[tail] <= bus.i_imem_rdata;
      q_pc[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for streaming and
// backpressure, hand sequences for redirect, wait states, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  int          gnt_dly;
  int          r_dly;
  int          gwait;
  int          rwait;
  logic        pend;
  logic [31:0] paddr;

  typedef struct {
    bit          ns;
    bit          rdy;
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          rq;
    logic [31:0] ad;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mdata(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic settle();
    #1;
    bus.i_imem_gnt    = bus.o_imem_req && (gwait >= gnt_dly);
    bus.i_imem_rvalid = pend && (rwait >= r_dly);
    bus.i_imem_rdata  = pend ? mdata(paddr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic advance();
    logic        g;
    logic        rv;
    logic        rq;
    logic [31:0] a;
    g  = bus.i_imem_gnt;
    rv = bus.i_imem_rvalid;
    rq = bus.o_imem_req;
    a  = bus.o_imem_addr;
    @(posedge clk);
    if (rv) pend = 1'b0;
    else if (pend) rwait++;
    if (g === 1'b1) begin
      pend  = 1'b1;
      paddr = a;
      rwait = 1;
      gwait = 0;
    end else if (rq === 1'b1) gwait++;
    else gwait = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    settle();
    advance();
    rst_n = 1'b1;
    pend  = 1'b0;
    gwait = 0;
    rwait = 0;
  endtask

  task automatic add(bit ns, bit rdy, bit v, logic [31:0] pc,
                     bit rq, logic [31:0] ad);
    vec_t r;
    r.ns  = ns;
    r.rdy = rdy;
    r.v   = v;
    r.pc  = v ? pc : 32'h0;
    r.ins = v ? mdata(pc) : 32'h13;
    r.rq  = rq;
    r.ad  = ad;
    tbl.push_back(r);
  endtask

  initial begin
    logic        found;
    logic        seen;
    logic        hold;
    logic [31:0] hold_addr;
    logic [31:0] exp5 [4];
    int          got;

    rst_n             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 32'h0;
    bus.i_ready       = 1'b1;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;
    gnt_dly = 0;
    r_dly   = 1;
    gwait   = 0;
    rwait   = 0;
    pend    = 1'b0;
    paddr   = 32'h0;

    // streaming, zero-wait memory
    add(1, 1, 0, 32'h0, 1, 32'h0);
    add(0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h0, 1, 32'h4);
    add(0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h4, 1, 32'h8);
    add(0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'hC);
    add(0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'hC, 1, 32'h10);
    // backpressure: ready low for 10 cycles
    add(1, 0, 0, 32'h0, 1, 32'h0);
    add(0, 0, 0, 32'h0, 0, 32'h0);
    add(0, 0, 1, 32'h0, 1, 32'h4);
    add(0, 0, 1, 32'h0, 0, 32'h0);
    for (int k = 0; k < 6; k++) add(0, 0, 1, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h4, 1, 32'h8);
    add(0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'hC);

    @(negedge clk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].ns) do_reset();
      bus.i_ready = tbl[i].rdy;
      redirect    = 1'b0;
      settle();
      chk($sformatf("t%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d_pc", i), bus.o_pc, tbl[i].pc);
      chk($sformatf("t%0d_instr", i), bus.o_instr, tbl[i].ins);
      chk($sformatf("t%0d_req", i), 32'(bus.o_imem_req), 32'(tbl[i].rq));
      if (tbl[i].rq) chk($sformatf("t%0d_addr", i), bus.o_imem_addr, tbl[i].ad);
      advance();
    end

    // redirect while waiting for the response of PC 8
    do_reset();
    r_dly = 3;
    bus.i_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      settle();
      if (bus.i_imem_gnt && bus.o_imem_addr == 32'h8) found = 1'b1;
      advance();
    end
    chk("s3_grant8_seen", 32'(found), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    settle();
    chk("s3_redir_req", 32'(bus.o_imem_req), 32'h0);
    advance();
    redirect = 1'b0;
    settle();
    chk("s3_flush_valid", 32'(bus.o_valid), 32'h0);
    seen  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      settle();
      if (bus.o_imem_req && !seen) begin
        chk("s3_req_addr", bus.o_imem_addr, 32'h100);
        seen = 1'b1;
      end
      if (bus.o_valid) begin
        chk("s3_pc", bus.o_pc, 32'h100);
        chk("s3_instr", bus.o_instr, mdata(32'h100));
        found = 1'b1;
      end
      advance();
    end
    chk("s3_valid_seen", 32'(found), 32'h1);

    // redirect coincident with rvalid, queue holding PC 0
    do_reset();
    r_dly = 1;
    bus.i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      advance();
    end
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    settle();
    chk("s4_rvalid_cycle_req", 32'(bus.o_imem_req), 32'h0);
    chk("s4_pre_pc", bus.o_pc, 32'h0);
    advance();
    redirect = 1'b0;
    settle();
    chk("s4_flush_valid", 32'(bus.o_valid), 32'h0);
    chk("s4_flush_instr", bus.o_instr, 32'h13);
    chk("s4_req", 32'(bus.o_imem_req), 32'h1);
    chk("s4_addr", bus.o_imem_addr, 32'h200);
    advance();
    settle();
    advance();
    settle();
    chk("s4_pc", bus.o_pc, 32'h200);
    chk("s4_instr", bus.o_instr, mdata(32'h200));
    advance();

    // slow memory and fetch PC wrap
    do_reset();
    gnt_dly = 3;
    r_dly   = 4;
    bus.i_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    settle();
    chk("s5_redir_req", 32'(bus.o_imem_req), 32'h0);
    advance();
    redirect = 1'b0;
    exp5[0] = 32'hFFFF_FFF8;
    exp5[1] = 32'hFFFF_FFFC;
    exp5[2] = 32'h0000_0000;
    exp5[3] = 32'h0000_0004;
    got  = 0;
    hold = 1'b0;
    hold_addr = 32'h0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      settle();
      if (hold && bus.o_imem_req)
        chk("s5_addr_hold", bus.o_imem_addr, hold_addr);
      hold      = bus.o_imem_req && !bus.i_imem_gnt;
      hold_addr = bus.o_imem_addr;
      if (bus.o_valid) begin
        chk($sformatf("s5_pc%0d", got), bus.o_pc, exp5[got]);
        chk($sformatf("s5_instr%0d", got), bus.o_instr, mdata(exp5[got]));
        got++;
      end
      advance();
    end
    chk("s5_count", got, 4);

    // reset with queue reserved full and a request outstanding
    do_reset();
    gnt_dly = 0;
    r_dly   = 3;
    bus.i_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      settle();
      if (bus.i_imem_gnt && bus.o_imem_addr == 32'h4) found = 1'b1;
      advance();
    end
    chk("s6_grant4_seen", 32'(found), 32'h1);
    settle();
    chk("s6_pre_valid", 32'(bus.o_valid), 32'h1);
    rst_n = 1'b0;
    settle();
    advance();
    rst_n   = 1'b1;
    gnt_dly = 1000;
    settle();
    chk("s6_valid", 32'(bus.o_valid), 32'h0);
    chk("s6_instr", bus.o_instr, 32'h13);
    chk("s6_pc", bus.o_pc, 32'h0);
    chk("s6_req", 32'(bus.o_imem_req), 32'h1);
    chk("s6_addr", bus.o_imem_addr, 32'h0);
    for (int c = 0; c < 5; c++) begin
      advance();
      settle();
      chk($sformatf("s6_stray%0d", c), 32'(bus.o_valid), 32'h0);
    end
    chk("s6_stray_done", 32'(pend), 32'h0);
    gnt_dly = 0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      settle();
      if (bus.o_valid) begin
        chk("s6_post_pc", bus.o_pc, 32'h0);
        chk("s6_post_instr", bus.o_instr, mdata(32'h0));
        found = 1'b1;
      end
      advance();
    end
    chk("s6_post_seen", 32'(found), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
